mem_access_ctrl: RTL and testbench

Sequencing controller between the CPU datapath's load/store unit and the 256-byte RAM. It accepts one memory request at a time through a ready/req/done handshake and runs the RAM's enable/w_r/access_mode/MOC protocol for that request. It checks alignment, applies optional sign extension to byte and halfword loads, and times out writes whose MOC never arrives. Output pins connect directly to the RAM's data, address, w_r, enable, access_mode, state and mem ports.

---
 rtl/mem_access_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the 256-byte RAM: handshake with the LSU, drives the
// RAM enable/w_r/access_mode/MOC protocol, checks alignment and formats loads.
module mem_access_ctrl #(
    parameter int READ_WAIT = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  mode,
    input  logic        sign_ext,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] ram_data,
    output logic [7:0]  ram_addr,
    output logic        ram_w_r,
    output logic        ram_enable,
    output logic [1:0]  ram_mode,
    input  logic        ram_moc,
    input  logic [31:0] ram_mem
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_DONE, S_ERR
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_ram_data;
    logic [7:0]  r_ram_addr;
    logic [1:0]  r_ram_mode;
    logic        r_ram_w_r;
    logic        r_sx;
    logic        w_bad;
    logic        w_accept;
    logic [31:0] w_fmt;

    assign w_bad = (mode == 2'b11) ||
                   (mode == 2'b01 && addr[0]) ||
                   (mode == 2'b10 && addr[1:0] != 2'b00);
    assign w_accept = (r_state == S_IDLE) && req && !w_bad;

    always_comb begin
        case (r_ram_mode)
            2'b00:   w_fmt = r_sx ? {{24{ram_mem[7]}}, ram_mem[7:0]}
                                  : {24'h0, ram_mem[7:0]};
            2'b01:   w_fmt = r_sx ? {{16{ram_mem[15]}}, ram_mem[15:0]}
                                  : {16'h0, ram_mem[15:0]};
            default: w_fmt = ram_mem;
        endcase
    end

    // RAM pin registers only load on a legal request, so rejected requests
    // never produce a w_r edge at the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'd0;
            r_ram_data <= 32'd0;
            r_ram_addr <= 8'd0;
            r_ram_mode <= 2'd0;
            r_ram_w_r  <= 1'b1;
            r_sx       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ram_data <= wdata;
                r_ram_addr <= addr;
                r_ram_mode <= mode;
                r_ram_w_r  <= ~wr;
                r_sx       <= sign_ext;
            end
            if (r_state == S_STROBE)
                r_cnt <= 4'd0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 4'd1;
            if (r_state == S_WAIT && r_ram_w_r && r_cnt == RD_LAST)
                r_rdata <= w_fmt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req) w_next = w_bad ? S_ERR : S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_WAIT;
            S_WAIT: begin
                if (r_ram_w_r) begin
                    if (r_cnt == RD_LAST) w_next = S_DONE;
                end else if (ram_moc) begin
                    w_next = S_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign ready      = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE) || (r_state == S_ERR);
    assign fault      = (r_state == S_ERR);
    assign ram_enable = (r_state == S_STROBE) || (r_state == S_WAIT);
    assign rdata      = r_rdata;
    assign ram_data   = r_ram_data;
    assign ram_addr   = r_ram_addr;
    assign ram_mode   = r_ram_mode;
    assign ram_w_r    = r_ram_w_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a zero-delay behavioural RAM model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        sign_ext = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, fault;
    logic [31:0] rdata, ram_data, ram_mem;
    logic [7:0]  ram_addr;
    logic        ram_w_r, ram_enable, ram_moc;
    logic [1:0]  ram_mode;

    logic        no_moc = 1'b0;
    logic [7:0]  mem [0:255];
    int          checks = 0;
    int          failures = 0;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .mode(mode),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
        .done(done), .fault(fault), .rdata(rdata), .ram_data(ram_data),
        .ram_addr(ram_addr), .ram_w_r(ram_w_r), .ram_enable(ram_enable),
        .ram_mode(ram_mode), .ram_moc(ram_moc), .ram_mem(ram_mem)
    );

    always #5 clk = ~clk;

    // RAM model: writes on rising enable, reads combinationally, big-endian.
    assign ram_moc = ram_enable & ~no_moc;

    always_comb begin
        case (ram_mode)
            2'b00:   ram_mem = {24'h0, mem[ram_addr]};
            2'b01:   ram_mem = {16'h0, mem[ram_addr], mem[ram_addr + 8'd1]};
            default: ram_mem = {mem[ram_addr], mem[ram_addr + 8'd1],
                                mem[ram_addr + 8'd2], mem[ram_addr + 8'd3]};
        endcase
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(posedge ram_enable);
            if (!ram_w_r) begin
                case (ram_mode)
                    2'b00: mem[ram_addr] = ram_data[7:0];
                    2'b01: begin
                        mem[ram_addr]        = ram_data[15:8];
                        mem[ram_addr + 8'd1] = ram_data[7:0];
                    end
                    default: begin
                        mem[ram_addr]        = ram_data[31:24];
                        mem[ram_addr + 8'd1] = ram_data[23:16];
                        mem[ram_addr + 8'd2] = ram_data[15:8];
                        mem[ram_addr + 8'd3] = ram_data[7:0];
                    end
                endcase
            end
        end
    end

    // Issues one request and reports cycles from acceptance to done (0 = never).
    task automatic do_req(input logic w, input logic [1:0] m, input logic sx,
                          input logic [7:0] a, input logic [31:0] d,
                          output int lat, output logic flt,
                          output logic [31:0] rd, output logic en_seen);
        @(negedge clk);
        req = 1'b1; wr = w; mode = m; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; flt = 1'b0; rd = 32'h0; en_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ram_enable) en_seen = 1'b1;
            if (done) begin
                lat = i; flt = fault; rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (ram_w_r !== 1'b1) begin failures++; $display("FAIL reset_w_r got=%b exp=1", ram_w_r); end
        checks++; if ({ram_enable, done, fault} !== 3'b000) begin failures++; $display("FAIL reset_en_done_fault got=%b exp=000", {ram_enable, done, fault}); end
        checks++; if ({rdata, ram_data, ram_addr, ram_mode} !== 74'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {rdata, ram_data, ram_addr, ram_mode}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", ready); end
    endtask

    task automatic test_word();
        int lat; logic flt, en; logic [31:0] rd;
        do_req(1'b1, 2'b10, 1'b0, 8'h08, 32'hCACABABA, lat, flt, rd, en);
        checks++; if (lat !== 4) begin failures++; $display("FAIL word_store_lat got=%0d exp=4", lat); end
        checks++; if (flt !== 1'b0) begin failures++; $display("FAIL word_store_fault got=%b exp=0", flt); end
        checks++; if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hCACABABA) begin failures++; $display("FAIL word_store_mem got=%h exp=CACABABA", {mem[8], mem[9], mem[10], mem[11]}); end
        do_req(1'b0, 2'b10, 1'b1, 8'h08, 32'h0, lat, flt, rd, en);
        checks++; if (lat !== 5) begin failures++; $display("FAIL word_load_lat got=%0d exp=5", lat); end
        checks++; if (rd !== 32'hCACABABA) begin failures++; $display("FAIL word_load_data got=%h exp=CACABABA", rd); end
        checks++; if (flt !== 1'b0) begin failures++; $display("FAIL word_load_fault got=%b exp=0", flt); end
    endtask

    task automatic test_byte();
        int lat; logic flt, en; logic [31:0] rd;
        do_req(1'b1, 2'b00, 1'b0, 8'h00, 32'h000000CC, lat, flt, rd, en);
        checks++; if (lat !== 4) begin failures++; $display("FAIL byte_store_lat got=%0d exp=4", lat); end
        do_req(1'b0, 2'b00, 1'b1, 8'h00, 32'h0, lat, flt, rd, en);
        checks++; if (rd !== 32'hFFFFFFCC) begin failures++; $display("FAIL byte_load_sx got=%h exp=FFFFFFCC", rd); end
        do_req(1'b0, 2'b00, 1'b0, 8'h00, 32'h0, lat, flt, rd, en);
        checks++; if (rd !== 32'h000000CC) begin failures++; $display("FAIL byte_load_zx got=%h exp=000000CC", rd); end
        checks++; if (lat !== 5) begin failures++; $display("FAIL byte_load_lat got=%0d exp=5", lat); end
    endtask

    task automatic test_half();
        int lat; logic flt, en; logic [31:0] rd;
        do_req(1'b1, 2'b01, 1'b0, 8'h04, 32'h0000BABA, lat, flt, rd, en);
        do_req(1'b0, 2'b01, 1'b1, 8'h04, 32'h0, lat, flt, rd, en);
        checks++; if (rd !== 32'hFFFFBABA) begin failures++; $display("FAIL half_load_sx_neg got=%h exp=FFFFBABA", rd); end
        do_req(1'b0, 2'b01, 1'b0, 8'h04, 32'h0, lat, flt, rd, en);
        checks++; if (rd !== 32'h0000BABA) begin failures++; $display("FAIL half_load_zx got=%h exp=0000BABA", rd); end
        do_req(1'b1, 2'b01, 1'b0, 8'h04, 32'h00007ABA, lat, flt, rd, en);
        do_req(1'b0, 2'b01, 1'b1, 8'h04, 32'h0, lat, flt, rd, en);
        checks++; if (rd !== 32'h00007ABA) begin failures++; $display("FAIL half_load_sx_pos got=%h exp=00007ABA", rd); end
    endtask

    task automatic test_misaligned();
        int lat; logic flt, en; logic [31:0] rd;
        do_req(1'b1, 2'b01, 1'b0, 8'h03, 32'hFFFFFFFF, lat, flt, rd, en);
        checks++; if ({lat, flt, en} !== {32'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL mis_half lat/fault/en got=%0d/%b/%b exp=1/1/0", lat, flt, en); end
        checks++; if (rd !== 32'h00007ABA) begin failures++; $display("FAIL mis_rdata_held got=%h exp=00007ABA", rd); end
        do_req(1'b1, 2'b10, 1'b0, 8'h06, 32'hFFFFFFFF, lat, flt, rd, en);
        checks++; if ({lat, flt, en} !== {32'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL mis_word lat/fault/en got=%0d/%b/%b exp=1/1/0", lat, flt, en); end
        do_req(1'b1, 2'b11, 1'b0, 8'h00, 32'hFFFFFFFF, lat, flt, rd, en);
        checks++; if ({lat, flt, en} !== {32'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL illegal_mode lat/fault/en got=%0d/%b/%b exp=1/1/0", lat, flt, en); end
        checks++; if ({mem[0], mem[3], mem[4], mem[5], mem[6], mem[7]} !== 48'hCC007ABA0000) begin failures++; $display("FAIL mis_mem got=%h exp=CC007ABA0000", {mem[0], mem[3], mem[4], mem[5], mem[6], mem[7]}); end
    endtask

    task automatic test_timeout();
        int lat; logic flt, en; logic [31:0] rd;
        no_moc = 1'b1;
        do_req(1'b1, 2'b10, 1'b0, 8'h0C, 32'h12345678, lat, flt, rd, en);
        checks++; if (lat !== 18) begin failures++; $display("FAIL timeout_lat got=%0d exp=18", lat); end
        checks++; if (flt !== 1'b1) begin failures++; $display("FAIL timeout_fault got=%b exp=1", flt); end
        checks++; if (ram_enable !== 1'b0) begin failures++; $display("FAIL timeout_en got=%b exp=0", ram_enable); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL timeout_ready got=%b exp=1", ready); end
        no_moc = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic dn;
        no_moc = 1'b1;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; mode = 2'b10; addr = 8'h10; wdata = 32'h11223344;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (ram_enable !== 1'b1) begin failures++; $display("FAIL mid_en_before got=%b exp=1", ram_enable); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ram_enable !== 1'b0) begin failures++; $display("FAIL mid_en_async got=%b exp=0", ram_enable); end
        checks++; if ({ready, done, fault, ram_w_r} !== 4'b1001) begin failures++; $display("FAIL mid_outputs got=%b exp=1001", {ready, done, fault, ram_w_r}); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
        dn = 1'b0;
        repeat (3) begin @(negedge clk); if (done) dn = 1'b1; end
        rst_n = 1'b1;
        no_moc = 1'b0;
        repeat (3) begin @(negedge clk); if (done) dn = 1'b1; end
        checks++; if (dn !== 1'b0) begin failures++; $display("FAIL mid_no_done got=%b exp=0", dn); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", ready); end
    endtask

    task automatic test_ignored();
        int lat; logic dn, busy_ready;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; mode = 2'b10; sign_ext = 1'b0; addr = 8'h08; wdata = 32'h0;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; dn = 1'b0; busy_ready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ready) busy_ready = (lat == 0) ? 1'b1 : busy_ready;
            if (done && lat == 0) begin
                lat = i;
                checks++; if (rdata !== 32'hCACABABA) begin failures++; $display("FAIL ign_rdata got=%h exp=CACABABA", rdata); end
            end else if (done) begin
                dn = 1'b1;
            end
            if (i >= 1 && i <= 3) begin
                req = 1'b1; wr = 1'b1; mode = 2'b10; addr = 8'h20; wdata = 32'hDEADBEEF;
            end else begin
                req = 1'b0;
            end
        end
        checks++; if (lat !== 5) begin failures++; $display("FAIL ign_lat got=%0d exp=5", lat); end
        checks++; if (busy_ready !== 1'b0) begin failures++; $display("FAIL ign_ready_busy got=%b exp=0", busy_ready); end
        checks++; if (dn !== 1'b0) begin failures++; $display("FAIL ign_extra_done got=%b exp=0", dn); end
        checks++; if ({mem[32], mem[33], mem[34], mem[35]} !== 32'h0) begin failures++; $display("FAIL ign_mem got=%h exp=0", {mem[32], mem[33], mem[34], mem[35]}); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
